alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised successor to the team's 8-bit combinational ALU.
- Generic WIDTH; 3-bit COND selecting 8 operations, including a multi-cycle shift-add multiply.
- Valid/ready handshakes on both the input and the output side.
- Sits between the operand register file and the result writeback path; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- CLK  in  1  single system clock, rising edge.
- RST  in  1  reset: one clock; reset is asynchronous and active-high.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- COND  in  3  opcode.
- IN_VALID  in  1  A/B/COND valid.
- IN_READY  out  1  block can accept an operation.
- OUT  out  WIDTH  registered result.
- CARRY  out  1  carry/borrow/high-half flag.
- OUT_VALID  out  1  OUT/CARRY valid.
- OUT_READY  in  1  consumer accepts the result.

Behaviour:
- Opcodes:
  - 000 ADD: OUT=A+B, CARRY=carry out.
  - 001 SUB: OUT=A-B mod 2^WIDTH, CARRY=borrow (A<B unsigned).
  - 010 EQ: OUT={0,A==B}, CARRY=0.
  - 011 ONE: OUT={0,(A==1)||(B==1)}, CARRY=0.
  - 100 AND, 101 OR, 110 XOR: bitwise, CARRY=0.
  - 111 MUL: OUT=low WIDTH bits of A*B (unsigned), CARRY=OR of high WIDTH bits.
- Accept: an operation is accepted on a rising edge where IN_VALID && IN_READY.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept of a non-MUL op: result registered on that edge, go to DONE.
  - Accept of MUL: latch A/B, clear the product and counter, go to BUSY.
- BUSY:
  - One multiplier bit per cycle; counter runs 0..WIDTH-1.
  - After WIDTH BUSY edges, load OUT/CARRY and go to DONE.
  - IN_READY=0.
- DONE:
  - OUT_VALID=1; OUT/CARRY held stable while OUT_READY=0.
  - On OUT_READY=1, the result is consumed.
  - If a new op is accepted on the same edge, take the IDLE transitions for it (back-to-back, throughput 1 for non-MUL ops).
  - Otherwise go to IDLE.
- IN_READY = (state==IDLE) || (state==DONE && OUT_READY), combinational.
- Latency from accepting edge to OUT_VALID high: 1 edge for non-MUL ops, WIDTH+1 edges for MUL.
- Operands are sampled only at accept; later changes on A/B/COND have no effect.
- IN_VALID while IN_READY=0: ignored. Upstream holds the operation until accepted.
- Reset (async, any state, including mid-MUL):
  - state=IDLE, OUT=0, CARRY=0, OUT_VALID=0, counter=0, product=0.
  - IN_READY=1 immediately after reset deasserts.
- Arithmetic: ADD/SUB use a WIDTH+1-bit internal sum. MUL uses a 2*WIDTH-bit accumulator. No signed modes.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- When defined, adds outputs, all registered with OUT, reset to 0, held in DONE:
  - ZERO (OUT==0).
  - NEG (OUT[WIDTH-1]).
  - OVF (signed overflow for ADD/SUB; 0 for all other ops).
- When undefined, these ports and their logic are absent; everything else is identical.

Decomposition:
- Shared header alu_seq_defs.vh holds:
  - Opcode localparams OP_ADD..OP_MUL.
  - State encodings ST_IDLE/ST_BUSY/ST_DONE.
  - The COND width constant.
- One sub-module: alu_seq_mul, the WIDTH-parameterised shift-add multiplier.
  - Interface: start, A, B, done, 2*WIDTH product.
  - Owns the counter; reset by RST.
- The top holds the FSM, the single-cycle ops, and the output register.

Test Plan:
- WIDTH=8, ADD A=0x06 B=0x60, OUT_READY=1 -> OUT_VALID one edge after accept, OUT=0x66, CARRY=0.
- ADD 0xFF+0x01 -> OUT=0x00, CARRY=1. Then SUB 0x05-0x07 issued back-to-back on the consume edge -> OUT=0xFE, CARRY=1, no bubble.
- EQ 0x3C,0x3C -> OUT=0x01. ONE 0x00,0x01 -> OUT=0x01. ONE 0x02,0x03 -> OUT=0x00, CARRY=0 for each.
- MUL 0x10*0x11 -> IN_READY=0 for 8 cycles, OUT_VALID 9 edges after accept, OUT=0x10, CARRY=1. MUL 0x0F*0x0F -> OUT=0xE1, CARRY=0.
- Backpressure: ADD result with OUT_READY=0 for 3 cycles -> OUT/CARRY/OUT_VALID stable, IN_READY=0, A/B changes ignored. OUT_READY=1 -> consumed, then IDLE.
- Assert RST at MUL cycle 4 -> outputs 0 asynchronously, state IDLE. A fresh ADD 0x01+0x01 afterwards -> OUT=0x02, no stale MUL result ever presented.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and width constants for the sequential ALU.
// Stands in for the legacy alu_seq_defs.vh header; import with alu_seq_pkg::*.
package alu_seq_pkg;

  localparam int unsigned COND_W = 3;
  localparam int unsigned ST_W   = 2;

  localparam logic [COND_W-1:0] OP_ADD = 3'd0;
  localparam logic [COND_W-1:0] OP_SUB = 3'd1;
  localparam logic [COND_W-1:0] OP_EQ  = 3'd2;
  localparam logic [COND_W-1:0] OP_ONE = 3'd3;
  localparam logic [COND_W-1:0] OP_AND = 3'd4;
  localparam logic [COND_W-1:0] OP_OR  = 3'd5;
  localparam logic [COND_W-1:0] OP_XOR = 3'd6;
  localparam logic [COND_W-1:0] OP_MUL = 3'd7;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  typedef logic [COND_W-1:0] cond_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// ZERO/NEG/OVF exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
) ();
  import alu_seq_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  cond_t            COND;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] OUT;
  logic             CARRY;
  logic             OUT_VALID;
  logic             OUT_READY;
`ifdef ALU_SEQ_FLAGS_EN
  logic             ZERO;
  logic             NEG;
  logic             OVF;
`endif

  modport master (
    output A, B, COND, IN_VALID, OUT_READY,
    input  IN_READY, OUT, CARRY, OUT_VALID
`ifdef ALU_SEQ_FLAGS_EN
    , input ZERO, NEG, OVF
`endif
  );

  modport slave (
    input  A, B, COND, IN_VALID, OUT_READY,
    output IN_READY, OUT, CARRY, OUT_VALID
`ifdef ALU_SEQ_FLAGS_EN
    , output ZERO, NEG, OVF
`endif
  );

endinterface

// File: rtl/alu_seq_mul.sv
// WIDTH-cycle shift-add multiplier, one multiplier bit per clock.
// done_c_o/product_c_o flag and carry the final step so the caller can load on that same edge.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_c_o,
  output logic [2*WIDTH-1:0] product_c_o
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    step_c;
  logic             last_c;

  assign last_c      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign step_c      = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign done_c_o    = last_c;
  assign product_c_o = step_c;

  // A new start always wins, even on the cycle the previous product completes.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = PW'(a_i);
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prod_d   = step_c;
      cnt_d    = last_c ? '0 : cnt_q + CNT_W'(1);
      busy_d   = !last_c;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides; MUL runs on alu_seq_mul.
// Define ALU_SEQ_FLAGS_EN to add registered ZERO/NEG/OVF result flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic      CLK,
  input logic      RST,
  alu_seq_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [ST_W-1:0]  state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;

  logic             in_ready_c, accept_c, is_mul_c, mul_start_c, mul_done_c;
  logic [PW-1:0]    mul_prod_c;
  logic [WIDTH:0]   sum_c, diff_c;
  logic [WIDTH-1:0] op_out_c, ld_out_c;
  logic             op_carry_c, ld_carry_c, load_c;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic op_ovf_c, ld_ovf_c;
`endif

  assign in_ready_c  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.OUT_READY);
  assign accept_c    = bus.IN_VALID && in_ready_c;
  assign is_mul_c    = (bus.COND == OP_MUL);
  assign mul_start_c = accept_c && is_mul_c;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .CLK         (CLK),
    .RST         (RST),
    .start_i     (mul_start_c),
    .a_i         (bus.A),
    .b_i         (bus.B),
    .done_c_o    (mul_done_c),
    .product_c_o (mul_prod_c)
  );

  // Single-cycle datapath; borrow is the top bit of the widened difference.
  always_comb begin
    sum_c      = (WIDTH+1)'(bus.A) + (WIDTH+1)'(bus.B);
    diff_c     = (WIDTH+1)'(bus.A) - (WIDTH+1)'(bus.B);
    op_out_c   = '0;
    op_carry_c = 1'b0;
    case (bus.COND)
      OP_ADD:  {op_carry_c, op_out_c} = sum_c;
      OP_SUB:  {op_carry_c, op_out_c} = diff_c;
      OP_EQ:   op_out_c = WIDTH'(bus.A == bus.B);
      OP_ONE:  op_out_c = WIDTH'((bus.A == WIDTH'(1)) || (bus.B == WIDTH'(1)));
      OP_AND:  op_out_c = bus.A & bus.B;
      OP_OR:   op_out_c = bus.A | bus.B;
      OP_XOR:  op_out_c = bus.A ^ bus.B;
      default: op_out_c = '0;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_comb begin
    op_ovf_c = 1'b0;
    if (bus.COND == OP_ADD)
      op_ovf_c = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_c[WIDTH-1] != bus.A[WIDTH-1]);
    else if (bus.COND == OP_SUB)
      op_ovf_c = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_c[WIDTH-1] != bus.A[WIDTH-1]);
  end
`endif

  // Next state and result load; a consume edge in DONE may accept the next op directly.
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    ld_out_c   = op_out_c;
    ld_carry_c = op_carry_c;
`ifdef ALU_SEQ_FLAGS_EN
    ld_ovf_c   = op_ovf_c;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = is_mul_c ? ST_BUSY : ST_DONE;
          load_c  = !is_mul_c;
        end
      end
      ST_BUSY: begin
        if (mul_done_c) begin
          state_d    = ST_DONE;
          load_c     = 1'b1;
          ld_out_c   = mul_prod_c[WIDTH-1:0];
          ld_carry_c = |mul_prod_c[PW-1:WIDTH];
`ifdef ALU_SEQ_FLAGS_EN
          ld_ovf_c   = 1'b0;
`endif
        end
      end
      ST_DONE: begin
        if (accept_c) begin
          state_d = is_mul_c ? ST_BUSY : ST_DONE;
          load_c  = !is_mul_c;
        end else if (bus.OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_DONE);
    out_d   = out_q;
    carry_d = carry_q;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
`endif
    if (load_c) begin
      out_d   = ld_out_c;
      carry_d = ld_carry_c;
`ifdef ALU_SEQ_FLAGS_EN
      zero_d  = (ld_out_c == '0);
      neg_d   = ld_out_c[WIDTH-1];
      ovf_d   = ld_ovf_c;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.IN_READY  = in_ready_c;
  assign bus.OUT       = out_q;
  assign bus.CARRY     = carry_q;
  assign bus.OUT_VALID = valid_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign bus.ZERO      = zero_q;
  assign bus.NEG       = neg_q;
  assign bus.OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: directed table, hand sequences, random ops vs model.
module tb_alu_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] cond;
    logic [7:0] eo;
    logic       ec;
    int         lat;
    int         stall;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result from plain integer arithmetic; returns {carry, out}.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
    int   ia, ib, r;
    logic cy;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    cy = 1'b0;
    case (c)
      3'd0: begin r = ia + ib; cy = (r > 255); end
      3'd1: begin r = ia - ib; cy = (ia < ib); if (r < 0) r += 256; end
      3'd2: r = (ia == ib) ? 1 : 0;
      3'd3: r = (ia == 1 || ib == 1) ? 1 : 0;
      3'd4: r = ia & ib;
      3'd5: r = ia | ib;
      3'd6: r = ia ^ ib;
      default: begin r = ia * ib; cy = (r >= 256); end
    endcase
    return {cy, 8'(r % 256)};
  endfunction

  // Issue one op from idle, measure latency, stall the consumer, then consume.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] cond,
                       input logic [7:0] eo, input logic ec, input int lat, input int stall,
                       input string tag);
    int n;
    int rdy_bad;
    bus.A = a; bus.B = b; bus.COND = cond; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b0;
    #1;
    check({tag, " in_ready"}, 32'(bus.IN_READY), 32'd1);
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
    bus.A = 8'($urandom); bus.B = 8'($urandom); bus.COND = 3'($urandom);
    n = 1;
    rdy_bad = 0;
    while (!bus.OUT_VALID && n < 40) begin
      if (bus.IN_READY) rdy_bad++;
      bus.IN_VALID = 1'($urandom);
      bus.A = 8'($urandom); bus.B = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " busy_ready"}, 32'(rdy_bad), 32'd0);
    check({tag, " result"}, 32'({bus.CARRY, bus.OUT}), 32'({ec, eo}));
    for (int i = 0; i < stall; i++) begin
      bus.IN_VALID = 1'($urandom);
      bus.A = 8'($urandom); bus.B = 8'($urandom); bus.COND = 3'($urandom);
      @(posedge clk); #1;
      check({tag, " hold"}, 32'({bus.OUT_VALID, bus.IN_READY, bus.CARRY, bus.OUT}),
            32'({1'b1, 1'b0, ec, eo}));
    end
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    #1;
    check({tag, " consume_ready"}, 32'(bus.IN_READY), 32'd1);
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
    check({tag, " consumed"}, 32'(bus.OUT_VALID), 32'd0);
  endtask

  vec_t       vt[13];
  logic [8:0] m;
  logic [7:0] ra, rb;
  logic [2:0] rc;
  int         stale;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.A = '0; bus.B = '0; bus.COND = '0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;

    vt[0]  = '{8'h06, 8'h60, 3'd0, 8'h66, 1'b0, 1, 0};
    vt[1]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1, 0};
    vt[2]  = '{8'h05, 8'h07, 3'd1, 8'hFE, 1'b1, 1, 1};
    vt[3]  = '{8'h3C, 8'h3C, 3'd2, 8'h01, 1'b0, 1, 0};
    vt[4]  = '{8'h3C, 8'h3D, 3'd2, 8'h00, 1'b0, 1, 0};
    vt[5]  = '{8'h00, 8'h01, 3'd3, 8'h01, 1'b0, 1, 0};
    vt[6]  = '{8'h02, 8'h03, 3'd3, 8'h00, 1'b0, 1, 0};
    vt[7]  = '{8'hF0, 8'h3C, 3'd4, 8'h30, 1'b0, 1, 0};
    vt[8]  = '{8'hF0, 8'h0F, 3'd5, 8'hFF, 1'b0, 1, 0};
    vt[9]  = '{8'h10, 8'h11, 3'd7, 8'h10, 1'b1, 9, 0};
    vt[10] = '{8'h0F, 8'h0F, 3'd7, 8'hE1, 1'b0, 9, 2};
    vt[11] = '{8'h81, 8'h80, 3'd0, 8'h01, 1'b1, 1, 3};
    vt[12] = '{8'hAA, 8'hFF, 3'd6, 8'h55, 1'b0, 1, 0};

    #1 rst = 1'b1;
    #2;
    check("reset_outputs", 32'({bus.OUT_VALID, bus.CARRY, bus.OUT}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("reset_in_ready", 32'(bus.IN_READY), 32'd1);

    for (int i = 0; i < 13; i++)
      do_op(vt[i].a, vt[i].b, vt[i].cond, vt[i].eo, vt[i].ec, vt[i].lat, vt[i].stall,
            $sformatf("vec%0d", i));

    // ADD then SUB accepted on the consume edge: no bubble.
    bus.A = 8'hFF; bus.B = 8'h01; bus.COND = 3'd0; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b0;
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
    check("b2b add", 32'({bus.OUT_VALID, bus.CARRY, bus.OUT}), 32'({1'b1, 1'b1, 8'h00}));
    bus.A = 8'h05; bus.B = 8'h07; bus.COND = 3'd1; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
    #1;
    check("b2b ready", 32'(bus.IN_READY), 32'd1);
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
    check("b2b sub", 32'({bus.OUT_VALID, bus.CARRY, bus.OUT}), 32'({1'b1, 1'b1, 8'hFE}));
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
    check("b2b drain", 32'(bus.OUT_VALID), 32'd0);

    // Streaming non-MUL ops at one per clock with the consumer always ready.
    bus.OUT_READY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 3'($urandom_range(0, 6));
      bus.A = ra; bus.B = rb; bus.COND = rc; bus.IN_VALID = 1'b1;
      #1;
      check($sformatf("stream%0d ready", k), 32'(bus.IN_READY), 32'd1);
      @(posedge clk); #1;
      m = model(ra, rb, rc);
      check($sformatf("stream%0d result", k),
            32'({bus.OUT_VALID, bus.CARRY, bus.OUT}), 32'({1'b1, m}));
    end
    bus.IN_VALID = 1'b0;
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
    check("stream drain", 32'(bus.OUT_VALID), 32'd0);

    // Reset in the middle of a multiply; no stale product may surface.
    bus.A = 8'h10; bus.B = 8'h11; bus.COND = 3'd7; bus.IN_VALID = 1'b1;
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midmul reset outputs", 32'({bus.OUT_VALID, bus.CARRY, bus.OUT}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midmul in_ready", 32'(bus.IN_READY), 32'd1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.OUT_VALID) stale++;
    end
    check("midmul stale", 32'(stale), 32'd0);
    do_op(8'h01, 8'h01, 3'd0, 8'h02, 1'b0, 1, 0, "post_reset add");

    // Random ops against the reference model.
    for (int k = 0; k < 120; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 3'($urandom);
      m = model(ra, rb, rc);
      do_op(ra, rb, rc, m[7:0], m[8], (rc == 3'd7) ? 9 : 1, int'($urandom_range(0, 2)),
            $sformatf("rand%0d op%0d", k, rc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
